// File: rtl/activation_pkg.sv
// Shared types and default widths for the activation pipeline.
package activation_pkg;

    typedef enum logic [1:0] {
        ACT_BYPASS = 2'd0,
        ACT_RELU   = 2'd1,
        ACT_LEAKY  = 2'd2,
        ACT_CLIP   = 2'd3
    } act_mode_t;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_LANES      = 4;
    localparam int DEF_LEAK_SHIFT = 3;
    localparam int DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/act_lane.sv
// Combinational activation of one signed element; results never exceed the input range.
module act_lane
    import activation_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
    input  act_mode_t                    mode,
    input  logic signed [DATA_WIDTH-1:0] clip_max,
    input  logic signed [DATA_WIDTH-1:0] x,
    output logic signed [DATA_WIDTH-1:0] y
);

    localparam logic signed [DATA_WIDTH-1:0] ZERO = '0;

    logic signed [DATA_WIDTH-1:0] clip_lim;

    // A negative bound collapses the clip window to exactly zero.
    assign clip_lim = (clip_max > ZERO) ? clip_max : ZERO;

    // NOTE: y gets a default before the case so no path can infer a latch.
    always_comb begin
        y = x;
        case (mode)
            ACT_BYPASS: y = x;
            ACT_RELU:   y = (x > ZERO) ? x : ZERO;
            ACT_LEAKY:  y = (x > ZERO) ? x : (x >>> LEAK_SHIFT);
            ACT_CLIP: begin
                if (x < ZERO)
                    y = ZERO;
                else if (x > clip_lim)
                    y = clip_lim;
                else
                    y = x;
            end
            default:    y = x;
        endcase
    end

endmodule

// File: rtl/activation_pipe.sv
// Two-stage valid/ready activation pipeline over LANES packed elements,
// with a per-frame output beat counter and end-of-frame done pulse.
module activation_pipe
    import activation_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LANES      = DEF_LANES,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  mode,
    input  logic [DATA_WIDTH-1:0]       clip_max,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic                        out_last,
    output logic [CNT_WIDTH-1:0]        beat_count,
    output logic                        done
);

    localparam int W = LANES * DATA_WIDTH;

    act_mode_t      in_mode;
    logic [W-1:0]   lane_y;

    logic           run;
    logic           s1_valid, s1_last;
    logic [W-1:0]   s1_data;
    logic           s2_valid, s2_last;
    logic [W-1:0]   s2_data;

    logic           s2_load, s1_moves, in_xfer, out_xfer;

    assign in_mode = act_mode_t'(mode);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        act_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_lane (
            .mode     (in_mode),
            .clip_max ($signed(clip_max)),
            .x        ($signed(in_data[g*DATA_WIDTH +: DATA_WIDTH])),
            .y        (lane_y[g*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Each stage accepts when empty or when its current beat leaves this cycle.
    assign s2_load  = ~s2_valid | out_ready;
    assign s1_moves = s1_valid & s2_load;
    assign in_ready = run & (~s1_valid | s1_moves);
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = s2_valid & out_ready;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run        <= 1'b0;
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s2_valid   <= 1'b0;
            s2_last    <= 1'b0;
            s2_data    <= '0;
            beat_count <= '0;
            done       <= 1'b0;
        end else begin
            run  <= 1'b1;
            done <= out_xfer & s2_last;

            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid)
                    s1_last <= in_last;
            end

            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                    s2_last <= s1_last;
                end
            end

            if (out_xfer)
                beat_count <= s2_last ? '0 : beat_count + 1'b1;
        end
    end

    // NOTE: stage-1 data is qualified by s1_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (in_xfer)
            s1_data <= lane_y;
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_last  = s2_last;

endmodule

// File: tb/tb_activation_pipe.sv
// Directed and scoreboarded checks of activation_pipe at default parameters.
module tb_activation_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [15:0] clip_max;
    logic        in_valid, in_ready, in_last;
    logic [63:0] in_data;
    logic        out_valid, out_ready, out_last;
    logic [63:0] out_data;
    logic [15:0] beat_count;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    activation_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .clip_max   (clip_max),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .beat_count (beat_count),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    // Reference activation written with integer arithmetic.
    function automatic logic [15:0] ref_lane(input logic [1:0] m, input int x, input int cm);
        int c, y;
        case (m)
            2'd0: y = x;
            2'd1: y = (x > 0) ? x : 0;
            2'd2: y = (x > 0) ? x : -((-x + 7) / 8);
            default: begin
                c = (cm > 0) ? cm : 0;
                y = (x < 0) ? 0 : ((x > c) ? c : x);
            end
        endcase
        return y[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single beat through an idle pipe with out_ready held high.
    task automatic one_beat(input string tag, input logic [1:0] m, input int cm,
                            input logic [63:0] d, input logic l, input logic [63:0] exp,
                            input int exp_cnt, input logic exp_done);
        logic [15:0] cmv;
        cmv = cm[15:0];
        mode = m; clip_max = cmv; in_data = d; in_last = l; in_valid = 1'b1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        mode = ~m; clip_max = 16'h7abc; in_data = ~d;
        check({tag, "_lat1"}, 64'(out_valid), 64'(0));
        tick();
        check({tag, "_valid"}, 64'(out_valid), 64'(1));
        check({tag, "_data"}, out_data, exp);
        check({tag, "_last"}, 64'(out_last), 64'(l));
        tick();
        check({tag, "_cnt"}, 64'(beat_count), 64'(exp_cnt));
        check({tag, "_done"}, 64'(done), 64'(exp_done));
        check({tag, "_empty"}, 64'(out_valid), 64'(0));
    endtask

    logic [64:0] q[$];

    initial begin
        rst = 1'b1; mode = 2'd0; clip_max = '0; in_valid = 1'b0;
        in_data = '0; in_last = 1'b0; out_ready = 1'b1;

        repeat (2) tick();
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", out_data, 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_cnt", 64'(beat_count), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        rst = 1'b0;
        check("rel_in_ready_pre", 64'(in_ready), 64'(0));
        tick();
        check("rel_in_ready", 64'(in_ready), 64'(1));

        // Five-beat frame: the last beat clears the counter and pulses done.
        one_beat("bypass", 2'd0, 0, pk(-1, 100, -32768, 32767), 1'b0,
                 pk(-1, 100, -32768, 32767), 1, 1'b0);
        one_beat("relu", 2'd1, 0, pk(-5, 0, 7, -32768), 1'b0,
                 pk(0, 0, 7, 0), 2, 1'b0);
        one_beat("leaky", 2'd2, 0, pk(-16, -1, 8, 32767), 1'b0,
                 pk(-2, -1, 8, 32767), 3, 1'b0);
        one_beat("clip6", 2'd3, 6, pk(10, 3, -4, 6), 1'b0,
                 pk(6, 3, 0, 6), 4, 1'b0);
        one_beat("clipneg", 2'd3, -3, pk(10, 3, -4, 6), 1'b1,
                 pk(0, 0, 0, 0), 0, 1'b1);
        tick();
        check("done_one_cycle", 64'(done), 64'(0));

        // Random-backpressure stream with per-beat mode changes.
        fork
            begin : producer
                for (int i = 0; i < 10; i++) begin
                    int lanes[4];
                    logic [15:0] r;
                    logic [63:0] d, e;
                    logic [1:0] m;
                    int cm, guard;
                    logic acc;
                    m = 2'(i % 4);
                    r = 16'($urandom_range(0, 20));
                    cm = int'(r) - 5;
                    for (int k = 0; k < 4; k++) begin
                        r = 16'($urandom);
                        lanes[k] = int'($signed(r));
                    end
                    d = pk(lanes[0], lanes[1], lanes[2], lanes[3]);
                    e = {ref_lane(m, lanes[3], cm), ref_lane(m, lanes[2], cm),
                         ref_lane(m, lanes[1], cm), ref_lane(m, lanes[0], cm)};
                    mode = m; clip_max = cm[15:0]; in_data = d;
                    in_last = (i == 9); in_valid = 1'b1;
                    acc = 1'b0; guard = 0;
                    while (!acc && guard < 400) begin
                        @(negedge clk);
                        acc = in_ready;
                        tick();
                        guard++;
                    end
                    q.push_back({(i == 9), e});
                    in_valid = 1'b0;
                end
                in_last = 1'b0;
            end
            begin : consumer
                int got, cyc, cnt;
                logic [64:0] e;
                got = 0; cyc = 0; cnt = 0;
                while (got < 10 && cyc < 400) begin
                    tick();
                    out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    cyc++;
                    if (out_valid && out_ready) begin
                        if (q.size() == 0) begin
                            check("stream_extra", 64'(1), 64'(0));
                        end else begin
                            e = q.pop_front();
                            check("stream_data", out_data, e[63:0]);
                            check("stream_last", 64'(out_last), 64'(e[64]));
                            check("stream_cnt", 64'(beat_count), 64'(cnt));
                            cnt = e[64] ? 0 : cnt + 1;
                        end
                        got++;
                    end
                end
                check("stream_count", 64'(got), 64'(10));
                tick();
                out_ready = 1'b1;
                check("stream_done", 64'(done), 64'(1));
                check("stream_cnt_clr", 64'(beat_count), 64'(0));
            end
        join
        tick();

        // Stall: two beats held, input blocked, order kept on release.
        out_ready = 1'b0;
        mode = 2'd0; in_data = pk(1, -2, 3, -4); in_last = 1'b0; in_valid = 1'b1;
        tick();
        mode = 2'd1; in_data = pk(-8, 8, -1, 1);
        check("stall_in_ready_b", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        check("stall_full", 64'(in_ready), 64'(0));
        check("stall_head", out_data, pk(1, -2, 3, -4));
        tick();
        check("stall_hold", out_data, pk(1, -2, 3, -4));
        check("stall_hold_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
        tick();
        check("stall_second", out_data, pk(0, 8, 0, 1));
        tick();
        check("stall_drained", 64'(out_valid), 64'(0));
        check("stall_cnt", 64'(beat_count), 64'(2));

        // Reset with two beats in flight.
        out_ready = 1'b0;
        mode = 2'd0; in_data = pk(11, 12, 13, 14); in_valid = 1'b1;
        tick();
        in_data = pk(21, 22, 23, 24);
        tick();
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_cnt", 64'(beat_count), 64'(0));
        check("mid_rst_data", out_data, 64'(0));
        check("mid_rst_ready", 64'(in_ready), 64'(0));
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check("post_rst_ready", 64'(in_ready), 64'(1));
        check("post_rst_empty", 64'(out_valid), 64'(0));
        one_beat("post_rst", 2'd1, 0, pk(5, -5, 0, 1), 1'b0, pk(5, 0, 0, 1), 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
